// File: rtl/adc_pkg.sv
// Shared definitions for the MCP3008-style SPI ADC sampler: frame geometry,
// FSM state encodings and the command/result helper functions.
package adc_pkg;

  localparam int FrameBits    = 17;
  localparam int FirstDataBit = 8;
  localparam int AdcWidth     = 10;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_CS_SETUP = 3'd1;
  localparam logic [2:0] ST_SHIFT    = 3'd2;
  localparam logic [2:0] ST_CS_HOLD  = 3'd3;
  localparam logic [2:0] ST_DONE     = 3'd4;

  // Offset binary (0..1023) to two's complement (-512..511): flip the MSB.
  function automatic logic signed [AdcWidth-1:0] offset_to_signed(input logic [AdcWidth-1:0] raw);
    return {~raw[AdcWidth-1], raw[AdcWidth-2:0]};
  endfunction

  // MOSI level for a 1-based SCLK period: start, single-ended, D2..D0, then zeros.
  function automatic logic cmd_bit(input logic [4:0] period, input logic [2:0] channel);
    logic b;
    case (period)
      5'd1, 5'd2: b = 1'b1;
      5'd3:       b = channel[2];
      5'd4:       b = channel[1];
      5'd5:       b = channel[0];
      default:    b = 1'b0;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/spi_clk_gen.sv
// SPI clock divider: ClkDiv-cycle half periods, SCLK toggling only while
// shifting, edge strobes for the controlling FSM and a completed-period count.
module spi_clk_gen #(
  parameter int ClkDiv = 25
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run,
  input  logic       shift,
  output logic       sclk,
  output logic       half_tick,
  output logic       rise,
  output logic       fall,
  output logic [4:0] period
);

  localparam int CntW = (ClkDiv > 1) ? $clog2(ClkDiv) : 1;

  logic [CntW-1:0] cnt;

  // Strobes are high in the cycle whose closing edge changes SCLK.
  assign half_tick = run && (cnt == CntW'(ClkDiv - 1));
  assign rise      = half_tick && shift && !sclk;
  assign fall      = half_tick && shift && sclk;

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      sclk   <= 1'b0;
      period <= '0;
    end else if (!run) begin
      cnt    <= '0;
      sclk   <= 1'b0;
      period <= '0;
    end else if (half_tick) begin
      cnt <= '0;
      if (shift) sclk <= ~sclk;
      if (fall) period <= period + 5'd1;
    end else begin
      cnt <= cnt + CntW'(1);
    end
  end

endmodule

// File: rtl/adc_spi_sampler.sv
// Periodic single-ended conversion on a fixed MCP3008 channel; the 10-bit
// offset-binary result is presented as signed data with a one-cycle strobe.
module adc_spi_sampler
  import adc_pkg::*;
#(
  parameter int         ClkDiv       = 25,
  parameter int         SamplePeriod = 250000,
  parameter logic [2:0] Channel      = 3'd0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       Enable,
  output logic                       AdcCsN,
  output logic                       AdcSclk,
  output logic                       AdcMosi,
  input  logic                       AdcMiso,
  output logic signed [AdcWidth-1:0] DataOut,
  output logic                       DataValid,
  output logic                       Busy
);

  localparam int         TimerW     = $clog2(SamplePeriod);
  localparam logic [4:0] LastPeriod = 5'(FrameBits - 1);
  localparam logic [4:0] FirstShift = 5'(FirstDataBit - 1);

  logic [2:0]          state;
  logic [TimerW-1:0]   timer;
  logic [AdcWidth-1:0] shreg;
  logic                run, shift, half_tick, rise, fall;
  logic [4:0]          period;

  assign run   = (state == ST_CS_SETUP) || (state == ST_SHIFT) || (state == ST_CS_HOLD);
  assign shift = (state == ST_SHIFT);

  spi_clk_gen #(.ClkDiv(ClkDiv)) u_clk_gen (
    .clk       (clk),
    .rst_n     (rst_n),
    .run       (run),
    .shift     (shift),
    .sclk      (AdcSclk),
    .half_tick (half_tick),
    .rise      (rise),
    .fall      (fall),
    .period    (period)
  );

  // Held at zero while disabled so sampling starts on the first enabled cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer <= '0;
    end else if (!Enable) begin
      timer <= '0;
    end else if (timer == '0) begin
      timer <= TimerW'(SamplePeriod - 1);
    end else begin
      timer <= timer - TimerW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      AdcCsN    <= 1'b1;
      AdcMosi   <= 1'b0;
      DataOut   <= '0;
      DataValid <= 1'b0;
      Busy      <= 1'b0;
      shreg     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (Enable && (timer == '0)) begin
            state  <= ST_CS_SETUP;
            AdcCsN <= 1'b0;
            Busy   <= 1'b1;
            shreg  <= '0;
          end
        end
        ST_CS_SETUP: begin
          if (half_tick) begin
            state   <= ST_SHIFT;
            AdcMosi <= cmd_bit(5'd1, Channel);
          end
        end
        ST_SHIFT: begin
          // Sample and null periods precede the ten result bits.
          if (rise && (period >= FirstShift)) shreg <= {shreg[AdcWidth-2:0], AdcMiso};
          if (fall) begin
            if (period == LastPeriod) begin
              state   <= ST_CS_HOLD;
              AdcCsN  <= 1'b1;
              AdcMosi <= 1'b0;
            end else begin
              AdcMosi <= cmd_bit(period + 5'd2, Channel);
            end
          end
        end
        ST_CS_HOLD: begin
          if (half_tick) begin
            state     <= ST_DONE;
            DataOut   <= offset_to_signed(shreg);
            DataValid <= 1'b1;
          end
        end
        ST_DONE: begin
          state     <= ST_IDLE;
          DataValid <= 1'b0;
          Busy      <= 1'b0;
        end
        default: begin
          state  <= ST_IDLE;
          AdcCsN <= 1'b1;
          Busy   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adc_spi_sampler.sv
// Self-checking bench: behavioural MCP3008 model feeding a scoreboard of
// expected samples, plus a frame-timing monitor on the SPI pins.
module tb_adc_spi_sampler;

  localparam int         ClkDiv       = 2;
  localparam int         SamplePeriod = 100;
  localparam logic [2:0] Channel      = 3'd5;
  localparam logic [16:0] MosiExp     = {2'b11, Channel, 12'b0};

  logic clk = 1'b0;
  logic rst_n;
  logic enable;
  logic adc_csn, adc_sclk, adc_mosi;
  logic adc_miso = 1'b0;
  logic signed [9:0] data_out;
  logic data_valid, busy;

  adc_spi_sampler #(
    .ClkDiv       (ClkDiv),
    .SamplePeriod (SamplePeriod),
    .Channel      (Channel)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .Enable    (enable),
    .AdcCsN    (adc_csn),
    .AdcSclk   (adc_sclk),
    .AdcMosi   (adc_mosi),
    .AdcMiso   (adc_miso),
    .DataOut   (data_out),
    .DataValid (data_valid),
    .Busy      (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string tag, input logic signed [31:0] act, input logic signed [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // ADC model: result bits driven after SCLK falls, MSB in period 8.
  logic [9:0] raw_q[$];
  int         exp_q[$];
  logic [9:0] m_raw;
  int         m_period = 0;

  always @(negedge adc_csn) begin
    m_period = 1;
    m_raw    = (raw_q.size() > 0) ? raw_q.pop_front() : 10'h000;
    exp_q.push_back(int'(m_raw) - 512);
    adc_miso = 1'b0;
  end

  always @(negedge adc_sclk) begin
    if (adc_csn === 1'b0) begin
      logic [9:0] tmp;
      m_period++;
      tmp = m_raw << (m_period - 8);
      adc_miso = (m_period >= 8 && m_period <= 17) ? tmp[9] : 1'b0;
    end
  end

  // Pin monitor, sampled on the falling clk edge.
  int cyc = 0;
  always @(posedge clk) cyc++;

  int  cs_fall_cyc = 0, cs_rise_cyc = 0, cs_falls = 0;
  int  rises = 0, total_rises = 0, dv_count = 0;
  bit  have_cs_rise = 0;
  logic prev_csn = 1'b1, prev_sclk = 1'b0, prev_dv = 1'b0;
  logic [16:0] mosi_word = '0;
  int  dv_cyc_q[$];

  always @(negedge clk) begin
    if (rst_n !== 1'b1) begin
      prev_csn  = 1'b1;
      prev_sclk = 1'b0;
      prev_dv   = 1'b0;
    end else begin
      if (prev_csn && !adc_csn) begin
        cs_fall_cyc = cyc;
        cs_falls++;
        rises     = 0;
        mosi_word = '0;
        check("busy_at_start", busy, 1);
        if (have_cs_rise) check("cs_high_gap", int'(cyc - cs_rise_cyc >= ClkDiv), 1);
      end
      if (!prev_sclk && adc_sclk) begin
        rises++;
        total_rises++;
        mosi_word = {mosi_word[15:0], adc_mosi};
        if (rises == 1) check("cs_setup", cyc - cs_fall_cyc, 2 * ClkDiv);
      end
      if (!prev_csn && adc_csn) begin
        cs_rise_cyc  = cyc;
        have_cs_rise = 1;
        check("cs_low_len", cyc - cs_fall_cyc, 35 * ClkDiv);
        check("sclk_rises", rises, 17);
        check("mosi_cmd", mosi_word, MosiExp);
      end
      if (data_valid) begin
        dv_count++;
        dv_cyc_q.push_back(cyc);
        check("dv_width", prev_dv, 0);
        check("dv_latency", cyc - cs_fall_cyc, 36 * ClkDiv);
        check("busy_at_dv", busy, 1);
        check("dv_expected", int'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) check("data_out", data_out, exp_q.pop_front());
      end
      if (prev_dv && !data_valid) check("busy_fall", busy, 0);
      prev_csn  = adc_csn;
      prev_sclk = adc_sclk;
      prev_dv   = data_valid;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_dv(input int n, input int budget, input string tag);
    int k = 0;
    while (dv_count < n && k < budget) begin
      tick(1);
      k++;
    end
    check(tag, dv_count, n);
  endtask

  task automatic wait_period(input int p, input int budget, input string tag);
    int k = 0;
    while (!(m_period == p && adc_csn === 1'b0) && k < budget) begin
      tick(1);
      k++;
    end
    check(tag, m_period, p);
  endtask

  task automatic check_spacing(input string tag);
    for (int i = 1; i < dv_cyc_q.size(); i++)
      check(tag, dv_cyc_q[i] - dv_cyc_q[i-1], SamplePeriod);
  endtask

  initial begin
    int f0, r0;
    rst_n  = 1'b0;
    enable = 1'b0;
    tick(3);
    check("rst_csn", adc_csn, 1);
    check("rst_sclk", adc_sclk, 0);
    check("rst_mosi", adc_mosi, 0);
    check("rst_dout", data_out, 0);
    check("rst_dv", data_valid, 0);
    check("rst_busy", busy, 0);
    rst_n = 1'b1;

    // Disabled: no activity at all.
    f0 = cs_falls;
    r0 = total_rises;
    tick(500);
    check("idle_no_cs", cs_falls, f0);
    check("idle_no_sclk", total_rises, r0);
    check("idle_csn", adc_csn, 1);
    check("idle_dout", data_out, 0);

    // Full-scale, then minimum and mid-scale on consecutive frames.
    raw_q.push_back(10'h3FF);
    raw_q.push_back(10'h000);
    raw_q.push_back(10'h200);
    enable = 1'b1;
    tick(1);
    check("cs_on_enable", adc_csn, 0);
    wait_dv(1, 200, "frame1_done");
    tick(10);
    check("dout_hold", data_out, 511);
    wait_dv(3, 300, "frame3_done");
    enable = 1'b0;
    check_spacing("strobe_spacing");
    dv_cyc_q.delete();

    // Enable dropped mid-frame: the frame still completes.
    raw_q.push_back(10'h155);
    enable = 1'b1;
    wait_period(10, 200, "reach_period10");
    enable = 1'b0;
    wait_dv(4, 200, "late_frame_done");
    f0 = cs_falls;
    tick(300);
    check("no_more_frames", cs_falls, f0);
    check("no_more_dv", dv_count, 4);
    check("dout_after_drop", data_out, -171);
    dv_cyc_q.delete();

    // Asynchronous reset in the middle of a frame.
    raw_q.push_back(10'h2AB);
    enable = 1'b1;
    wait_period(12, 200, "reach_period12");
    #2 rst_n = 1'b0;
    #1;
    check("arst_csn", adc_csn, 1);
    check("arst_sclk", adc_sclk, 0);
    check("arst_dv", data_valid, 0);
    check("arst_dout", data_out, 0);
    enable = 1'b0;
    tick(3);
    rst_n = 1'b1;
    exp_q.delete();
    tick(50);
    check("arst_no_dv", dv_count, 4);
    check("arst_idle_csn", adc_csn, 1);

    // Ten back-to-back frames with random data.
    for (int i = 0; i < 10; i++) raw_q.push_back(10'($urandom_range(0, 1023)));
    enable = 1'b1;
    tick(1);
    check("cs_after_reset", adc_csn, 0);
    wait_dv(14, 1200, "random_frames_done");
    enable = 1'b0;
    check_spacing("random_spacing");
    tick(50);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "simulation time limit reached");
  end

endmodule
